// File: rtl/float_norm_round.sv
// Normalise/round/pack stage for the single-precision adder.
// Three register stages with a global stall; ROUND_EN selects RNE or truncation.
module float_norm_round #(
    parameter bit ROUND_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [27:0] in_man,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_res
);

    logic stall;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // ---------------- S1: capture / classify ----------------
    logic        s1_valid;
    logic        s1_sign;
    logic [7:0]  s1_exp;
    logic [27:0] s1_man;
    logic        s1_zero;
    logic [4:0]  s1_lz;
    logic [4:0]  lz_c;
    logic        lz_found;

    always_comb begin
        lz_c     = 5'd0;
        lz_found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!lz_found) begin
                if (in_man[i]) lz_found = 1'b1;
                else           lz_c     = lz_c + 5'd1;
            end
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every stage samples
    // the previous stage's pre-edge value, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) s1_valid <= 1'b0;
        else if (!stall) s1_valid <= in_valid;
    end

    // NOTE: datapath registers carry no reset; the valid bits alone decide
    // whether their contents mean anything.
    always_ff @(posedge clk) begin
        if (!stall) begin
            s1_sign <= in_sign;
            s1_exp  <= in_exp;
            s1_man  <= in_man;
            s1_zero <= (in_man == 28'd0);
            s1_lz   <= lz_c;
        end
    end

    // ---------------- S2: normalise ----------------
    logic               s2_valid;
    logic               s2_sign;
    logic               s2_zero;
    logic [26:0]        s2_man;
    logic signed [9:0]  s2_e;
    logic [26:0]        norm_man;
    logic signed [9:0]  norm_e;

    always_comb begin
        norm_man = s1_man[26:0];
        norm_e   = $signed({2'b00, s1_exp});
        if (s1_man[27]) begin
            // Right shift keeps the dropped bit alive in the sticky position.
            norm_man = {s1_man[27:2], s1_man[1] | s1_man[0]};
            norm_e   = $signed({2'b00, s1_exp}) + 10'sd1;
        end else if (!s1_man[26]) begin
            norm_man = s1_man[26:0] << s1_lz;
            norm_e   = $signed({2'b00, s1_exp}) - $signed({5'b00000, s1_lz});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) s2_valid <= 1'b0;
        else if (!stall) s2_valid <= s1_valid;
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            s2_sign <= s1_sign;
            s2_zero <= s1_zero;
            s2_man  <= norm_man;
            s2_e    <= norm_e;
        end
    end

    // ---------------- S3: round / pack ----------------
    logic               round_up;
    logic [23:0]        frac_sum;
    logic signed [9:0]  e_rnd;
    logic [31:0]        res_c;

    always_comb begin
        round_up = ROUND_EN & s2_man[2] & (s2_man[1] | s2_man[0] | s2_man[3]);
        frac_sum = {1'b0, s2_man[25:3]} + {23'd0, round_up};
        e_rnd    = frac_sum[23] ? s2_e + 10'sd1 : s2_e;
        if (s2_zero)
            res_c = 32'h0000_0000;
        else if (e_rnd <= 10'sd0)
            res_c = {s2_sign, 31'h0};
        else if (e_rnd >= 10'sd255)
            res_c = {s2_sign, 8'hFF, 23'h0};
        else
            res_c = {s2_sign, e_rnd[7:0], frac_sum[22:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_res   <= 32'h0;
        end else if (!stall) begin
            out_valid <= s2_valid;
            out_res   <= res_c;
        end
    end

endmodule
